// File: rtl/ccff_bank.sv
// Bank of parallel configuration chains. Data is shifted serially into a shadow
// image and copied to the active configuration Q in one atomic commit cycle.

module ccff_bank_chk #(
   parameter int CHAIN_LEN = 32,
   parameter int CNT_W     = 6
) (
   input logic             ck,
   input logic             rst,
   input logic             ready,
   input logic             busy,
   input logic             done,
   input logic [CNT_W-1:0] cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

   // Structural invariants of the load sequencer.
   a_ready_busy : assert property (@(posedge ck) disable iff (rst) ready |-> busy);
   a_done_idle  : assert property (@(posedge ck) disable iff (rst) done |-> !ready);
   a_done_pulse : assert property (@(posedge ck) disable iff (rst) done |=> !done);
   a_cnt_range  : assert property (@(posedge ck) disable iff (rst) cnt <= CNT_MAX);
endmodule

module ccff_bank #(
   parameter int NUM_CHAINS = 4,
   parameter int CHAIN_LEN  = 32,
   parameter bit RESET_VAL  = 1'b0
) (
   input  logic                             CK,
   input  logic                             RST,
   input  logic                             START,
   input  logic                             ABORT,
   input  logic [NUM_CHAINS-1:0]            D,
   input  logic                             VALID,
   output logic                             READY,
   output logic [NUM_CHAINS-1:0]            SO,
   output logic [NUM_CHAINS*CHAIN_LEN-1:0]  Q,
   output logic                             BUSY,
   output logic                             DONE,
   output logic                             ERR
);
   localparam int BANK_W = NUM_CHAINS * CHAIN_LEN;
   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   state_t                                state_r;
   state_t                                state_nxt_s;
   logic [CNT_W-1:0]                      cnt_r;
   logic [NUM_CHAINS-1:0][CHAIN_LEN-1:0]  shadow_r;
   logic [BANK_W-1:0]                     q_r;
   logic                                  err_r;
   logic                                  ready_s;
   logic                                  busy_s;
   logic                                  done_s;
   logic                                  start_acc_s;
   logic                                  abort_acc_s;
   logic                                  beat_s;
   logic                                  last_beat_s;

   // ABORT only counts in SHIFT, and there it suppresses a coincident beat.
   assign start_acc_s = (state_r == ST_IDLE) & START;
   assign abort_acc_s = (state_r == ST_SHIFT) & ABORT;
   assign beat_s      = VALID & ready_s & ~abort_acc_s;
   assign last_beat_s = beat_s & (cnt_r == LAST_CNT);

   // State register.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (abort_acc_s) begin
               state_nxt_s = ST_IDLE;
            end else if (last_beat_s) begin
               state_nxt_s = ST_COMMIT;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_COMMIT: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode; READY depends on state alone.
   always_comb begin
      ready_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b0;
         end
         ST_SHIFT: begin
            ready_s = 1'b1;
            busy_s  = 1'b1;
         end
         ST_COMMIT: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            ready_s = 1'b0;
         end
      endcase
   end

   // Beat counter: cleared on an accepted START, advanced on each beat.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         cnt_r <= '0;
      end else if (start_acc_s) begin
         cnt_r <= '0;
      end else if (beat_s) begin
         cnt_r <= cnt_r + CNT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Shadow chains: new bit enters at index 0, oldest bit sits at the tail.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         shadow_r <= {BANK_W{RESET_VAL}};
      end else if (beat_s) begin
         for (int c = 0; c < NUM_CHAINS; c++) begin
            shadow_r[c] <= {shadow_r[c][CHAIN_LEN-2:0], D[c]};
         end
      end else begin
         shadow_r <= shadow_r;
      end
   end

   // Active configuration only moves during the single COMMIT cycle.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         q_r <= {BANK_W{RESET_VAL}};
      end else if (state_r == ST_COMMIT) begin
         q_r <= shadow_r;
      end else begin
         q_r <= q_r;
      end
   end

   // Sticky abort flag.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         err_r <= 1'b0;
      end else if (start_acc_s) begin
         err_r <= 1'b0;
      end else if (abort_acc_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   // Shadow tail bits for daisy-chaining.
   always_comb begin
      SO = '0;
      for (int c = 0; c < NUM_CHAINS; c++) begin
         SO[c] = shadow_r[c][CHAIN_LEN-1];
      end
   end

   assign Q     = q_r;
   assign READY = ready_s;
   assign BUSY  = busy_s;
   assign DONE  = done_s;
   assign ERR   = err_r;

   ccff_bank_chk #(
      .CHAIN_LEN (CHAIN_LEN),
      .CNT_W     (CNT_W)
   ) u_chk (
      .ck    (CK),
      .rst   (RST),
      .ready (ready_s),
      .busy  (busy_s),
      .done  (done_s),
      .cnt   (cnt_r)
   );
endmodule

// File: tb/tb_ccff_bank.sv
// Directed bench for ccff_bank: three instances cover the default bank,
// a RESET_VAL=1 bank and the minimum two-flop chain.

module tb_ccff_bank;
   logic ck = 1'b0;
   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;

   // Instance a: 4 x 32, RESET_VAL=0
   logic rst_a, start_a, abort_a, valid_a, ready_a, busy_a, done_a, err_a;
   logic [3:0] d_a, so_a;
   logic [127:0] q_a;
   // Instance b: 4 x 32, RESET_VAL=1
   logic rst_b, start_b, abort_b, valid_b, ready_b, busy_b, done_b, err_b;
   logic [3:0] d_b, so_b;
   logic [127:0] q_b;
   // Instance c: 4 x 2, RESET_VAL=0
   logic rst_c, start_c, abort_c, valid_c, ready_c, busy_c, done_c, err_c;
   logic [3:0] d_c, so_c;
   logic [7:0] q_c;

   ccff_bank #(.NUM_CHAINS(4), .CHAIN_LEN(32), .RESET_VAL(1'b0)) u_dut_a (
      .CK(ck), .RST(rst_a), .START(start_a), .ABORT(abort_a), .D(d_a), .VALID(valid_a),
      .READY(ready_a), .SO(so_a), .Q(q_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a));
   ccff_bank #(.NUM_CHAINS(4), .CHAIN_LEN(32), .RESET_VAL(1'b1)) u_dut_b (
      .CK(ck), .RST(rst_b), .START(start_b), .ABORT(abort_b), .D(d_b), .VALID(valid_b),
      .READY(ready_b), .SO(so_b), .Q(q_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b));
   ccff_bank #(.NUM_CHAINS(4), .CHAIN_LEN(2), .RESET_VAL(1'b0)) u_dut_c (
      .CK(ck), .RST(rst_c), .START(start_c), .ABORT(abort_c), .D(d_c), .VALID(valid_c),
      .READY(ready_c), .SO(so_c), .Q(q_c), .BUSY(busy_c), .DONE(done_c), .ERR(err_c));

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; start_a = 1'b0; abort_a = 1'b0; valid_a = 1'b0; d_a = 4'h0;
      rst_b = 1'b1; start_b = 1'b0; abort_b = 1'b0; valid_b = 1'b0; d_b = 4'h0;
      rst_c = 1'b1; start_c = 1'b0; abort_c = 1'b0; valid_c = 1'b0; d_c = 4'h0;
      step();
      step();
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0000) begin
         errors++; $display("FAIL reset_status_a got %b exp 0000", {ready_a, busy_a, done_a, err_a});
      end
      checks++;
      if (q_a !== {128{1'b0}} || so_a !== 4'h0) begin
         errors++; $display("FAIL reset_q_a got q=%h so=%h exp all 0", q_a, so_a);
      end
      checks++;
      if (q_b !== {128{1'b1}} || so_b !== 4'hF) begin
         errors++; $display("FAIL reset_q_b got q=%h so=%h exp all 1", q_b, so_b);
      end
      checks++;
      if (q_c !== 8'h00 || {ready_c, busy_c, done_c, err_c} !== 4'b0000) begin
         errors++; $display("FAIL reset_c got q=%h st=%b exp 00/0000", q_c, {ready_c, busy_c, done_c, err_c});
      end
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      step();
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0000) begin
         errors++; $display("FAIL post_reset_idle got %b exp 0000", {ready_a, busy_a, done_a, err_a});
      end
   endtask

   task automatic test_basic_load();
      int early;
      early = 0;
      start_a = 1'b1; step(); start_a = 1'b0;
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b1100) begin
         errors++; $display("FAIL basic_shift_entry got %b exp 1100", {ready_a, busy_a, done_a, err_a});
      end
      valid_a = 1'b1; d_a = 4'b1010;
      for (int k = 1; k <= 32; k++) begin
         step();
         if (k < 32 && (done_a !== 1'b0 || ready_a !== 1'b1)) early++;
      end
      checks++;
      if (early !== 0) begin
         errors++; $display("FAIL basic_early_commit got %0d bad cycles exp 0", early);
      end
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0110 || q_a !== {128{1'b0}}) begin
         errors++; $display("FAIL basic_commit_cycle got st=%b q=%h exp 0110 q=0", {ready_a, busy_a, done_a, err_a}, q_a);
      end
      checks++;
      if (so_a !== 4'b1010) begin
         errors++; $display("FAIL basic_so got %b exp 1010", so_a);
      end
      valid_a = 1'b0;
      step();
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0000) begin
         errors++; $display("FAIL basic_after got %b exp 0000", {ready_a, busy_a, done_a, err_a});
      end
      checks++;
      if (q_a !== {32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000000}) begin
         errors++; $display("FAIL basic_q got %h exp ffffffff00000000ffffffff00000000", q_a);
      end
   endtask

   task automatic test_gapped();
      int bad;
      int gap;
      bad = 0;
      start_a = 1'b1; step(); start_a = 1'b0;
      for (int b = 0; b < 32; b++) begin
         valid_a = 1'b1; d_a = {3'b000, b[0]};
         step();
         if (b < 31) begin
            valid_a = 1'b0; d_a = 4'hF;
            gap = (b == 30) ? 5 : 1;
            for (int g = 0; g < gap; g++) begin
               step();
               if (done_a !== 1'b0 || ready_a !== 1'b1) bad++;
            end
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL gapped_hold got %0d bad gap cycles exp 0", bad);
      end
      checks++;
      if (done_a !== 1'b1) begin
         errors++; $display("FAIL gapped_done got %b exp 1", done_a);
      end
      valid_a = 1'b0;
      step();
      checks++;
      if (q_a !== {96'h0, 32'h55555555}) begin
         errors++; $display("FAIL gapped_q got %h exp 0..055555555", q_a);
      end
   endtask

   task automatic test_abort();
      start_a = 1'b1; step(); start_a = 1'b0;
      valid_a = 1'b1; d_a = 4'hF;
      repeat (10) step();
      abort_a = 1'b1;
      step();
      abort_a = 1'b0; valid_a = 1'b0;
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0001) begin
         errors++; $display("FAIL abort_status got %b exp 0001", {ready_a, busy_a, done_a, err_a});
      end
      checks++;
      if (q_a !== {96'h0, 32'h55555555}) begin
         errors++; $display("FAIL abort_q got %h exp 0..055555555", q_a);
      end
      step();
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0001) begin
         errors++; $display("FAIL abort_sticky got %b exp 0001", {ready_a, busy_a, done_a, err_a});
      end
      start_a = 1'b1; step(); start_a = 1'b0;
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b1100) begin
         errors++; $display("FAIL abort_restart got %b exp 1100", {ready_a, busy_a, done_a, err_a});
      end
      abort_a = 1'b1; step(); abort_a = 1'b0;
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0001) begin
         errors++; $display("FAIL abort_novalid got %b exp 0001", {ready_a, busy_a, done_a, err_a});
      end
   endtask

   task automatic test_stray();
      int bad;
      bad = 0;
      start_a = 1'b1; abort_a = 1'b1; step(); start_a = 1'b0; abort_a = 1'b0;
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b1100) begin
         errors++; $display("FAIL stray_start_abort got %b exp 1100", {ready_a, busy_a, done_a, err_a});
      end
      valid_a = 1'b1; d_a = 4'b0101;
      for (int k = 1; k <= 32; k++) begin
         start_a = (k == 6) ? 1'b1 : 1'b0;
         step();
         if (k < 32 && (done_a !== 1'b0 || ready_a !== 1'b1)) bad++;
      end
      start_a = 1'b0;
      checks++;
      if (bad !== 0 || done_a !== 1'b1) begin
         errors++; $display("FAIL stray_beatcount got bad=%0d done=%b exp 0/1", bad, done_a);
      end
      valid_a = 1'b0; abort_a = 1'b1;
      step();
      abort_a = 1'b0;
      checks++;
      if ({ready_a, busy_a, done_a, err_a} !== 4'b0000) begin
         errors++; $display("FAIL stray_commit_abort got %b exp 0000", {ready_a, busy_a, done_a, err_a});
      end
      checks++;
      if (q_a !== {32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF}) begin
         errors++; $display("FAIL stray_q got %h exp 00000000ffffffff00000000ffffffff", q_a);
      end
      step();
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL stray_single_done got done=%b busy=%b exp 0/0", done_a, busy_a);
      end
   endtask

   task automatic test_reset_mid();
      start_b = 1'b1; step(); start_b = 1'b0;
      valid_b = 1'b1; d_b = 4'h0;
      repeat (32) step();
      valid_b = 1'b0;
      step();
      checks++;
      if (q_b !== {128{1'b0}}) begin
         errors++; $display("FAIL rstmid_preload got %h exp 0", q_b);
      end
      start_b = 1'b1; step(); start_b = 1'b0;
      valid_b = 1'b1;
      repeat (20) step();
      #2;
      rst_b = 1'b1;
      #1;
      checks++;
      if (q_b !== {128{1'b1}} || so_b !== 4'hF) begin
         errors++; $display("FAIL rstmid_async_q got q=%h so=%h exp all 1", q_b, so_b);
      end
      checks++;
      if ({ready_b, busy_b, done_b, err_b} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_status got %b exp 0000", {ready_b, busy_b, done_b, err_b});
      end
      valid_b = 1'b0;
      step();
      rst_b = 1'b0; start_b = 1'b1;
      step();
      start_b = 1'b0;
      checks++;
      if ({ready_b, busy_b, done_b, err_b} !== 4'b1100 || q_b !== {128{1'b1}}) begin
         errors++; $display("FAIL rstmid_first_start got st=%b q=%h exp 1100 all 1", {ready_b, busy_b, done_b, err_b}, q_b);
      end
   endtask

   task automatic test_edge_size();
      start_c = 1'b1; step(); start_c = 1'b0;
      valid_c = 1'b1; d_c = 4'b0011;
      step();
      checks++;
      if ({so_c, ready_c, done_c} !== {4'b0000, 1'b1, 1'b0}) begin
         errors++; $display("FAIL edge_beat1 got so=%b rdy=%b done=%b exp 0000/1/0", so_c, ready_c, done_c);
      end
      d_c = 4'b0101;
      step();
      checks++;
      if ({so_c, ready_c, done_c} !== {4'b0011, 1'b0, 1'b1}) begin
         errors++; $display("FAIL edge_beat2 got so=%b rdy=%b done=%b exp 0011/0/1", so_c, ready_c, done_c);
      end
      valid_c = 1'b0;
      step();
      checks++;
      if (q_c !== 8'h1B || done_c !== 1'b0) begin
         errors++; $display("FAIL edge_q1 got q=%h done=%b exp 1b/0", q_c, done_c);
      end
      start_c = 1'b1; step(); start_c = 1'b0;
      valid_c = 1'b1; d_c = 4'b1100;
      step();
      checks++;
      if (so_c !== 4'b0101) begin
         errors++; $display("FAIL edge_so_prev got %b exp 0101", so_c);
      end
      valid_c = 1'b0; d_c = 4'b1111;
      step();
      step();
      checks++;
      if (so_c !== 4'b0101 || ready_c !== 1'b1) begin
         errors++; $display("FAIL edge_gap got so=%b rdy=%b exp 0101/1", so_c, ready_c);
      end
      valid_c = 1'b1; d_c = 4'b1001;
      step();
      checks++;
      if (so_c !== 4'b1100 || done_c !== 1'b1) begin
         errors++; $display("FAIL edge_so_two_back got so=%b done=%b exp 1100/1", so_c, done_c);
      end
      valid_c = 1'b0;
      step();
      checks++;
      if (q_c !== 8'hE1) begin
         errors++; $display("FAIL edge_q2 got %h exp e1", q_c);
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_gapped();
      test_abort();
      test_stray();
      test_reset_mid();
      test_edge_size();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
